// File: rtl/adc_conversion_sequencer.sv
// SAR / linear-ramp conversion sequencer for an external DAC plus comparator.
// SAR latency WIDTH*(SETTLE_CYCLES+1)+1 cycles. Ramp latency is codes_tried*(SETTLE_CYCLES+1)+1. No backpressure.
module adc_conversion_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             successive_approx,
    input  logic             comp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy
);

    localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SAR_START = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] dac_nxt, result_nxt;
    logic [CNT_W-1:0] settle_cnt, cnt_nxt;
    logic [IDX_W-1:0] bit_idx, idx_nxt;
    logic             mode, mode_nxt;
    logic             comp_meta, comp_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comp_meta <= 1'b0;
            comp_sync <= 1'b0;
        end else begin
            comp_meta <= comp_in;
            comp_sync <= comp_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dac_code   <= '0;
            result     <= '0;
            settle_cnt <= '0;
            bit_idx    <= '0;
            mode       <= 1'b0;
        end else begin
            state      <= state_nxt;
            dac_code   <= dac_nxt;
            result     <= result_nxt;
            settle_cnt <= cnt_nxt;
            bit_idx    <= idx_nxt;
            mode       <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        dac_nxt    = dac_code;
        result_nxt = result;
        cnt_nxt    = settle_cnt;
        idx_nxt    = bit_idx;
        mode_nxt   = mode;
        case (state)
            IDLE: begin
                dac_nxt = '0;
                cnt_nxt = '0;
                if (enable) begin
                    mode_nxt  = successive_approx;
                    state_nxt = SETTLE;
                    if (successive_approx) begin
                        dac_nxt = SAR_START;
                        idx_nxt = IDX_TOP;
                    end
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    dac_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (settle_cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DECIDE;
                end else begin
                    cnt_nxt = settle_cnt + 1'b1;
                end
            end
            DECIDE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    dac_nxt   = '0;
                end else if (mode) begin
                    if (!comp_sync)
                        dac_nxt[bit_idx] = 1'b0;
                    if (bit_idx == '0) begin
                        result_nxt = dac_nxt;
                        state_nxt  = DONE;
                    end else begin
                        dac_nxt[bit_idx - 1'b1] = 1'b1;
                        idx_nxt   = bit_idx - 1'b1;
                        state_nxt = SETTLE;
                    end
                end else begin
                    // Comparator trips one code past Vin; code 0 saturates instead of wrapping.
                    if (!comp_sync) begin
                        result_nxt = (dac_code == '0) ? '0 : dac_code - 1'b1;
                        state_nxt  = DONE;
                    end else if (dac_code == '1) begin
                        result_nxt = dac_code;
                        state_nxt  = DONE;
                    end else begin
                        dac_nxt   = dac_code + 1'b1;
                        state_nxt = SETTLE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                dac_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                dac_nxt   = '0;
            end
        endcase
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// Scoreboard bench: stimulus pushes expected {code, valid cycle}; a monitor pops on each result_valid pulse.
module tb_adc_conversion_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       successive_approx;
    logic       comp_in;
    logic [7:0] dac_code;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;

    int   vin;
    logic force_low;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic prev_vld = 1'b0;

    typedef struct { int res; int at; } exp_t;
    exp_t sb[$];

    assign comp_in = force_low ? 1'b0 : (vin >= int'(dac_code));

    adc_conversion_sequencer #(.WIDTH(8), .SETTLE_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .successive_approx (successive_approx),
        .comp_in           (comp_in),
        .dac_code          (dac_code),
        .result            (result),
        .result_valid      (result_valid),
        .busy              (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start(input logic m, input int v, output int s);
        vin = v;
        successive_approx = m;
        enable = 1'b1;
        s = cyc;
    endtask

    task automatic push(input int r, input int at);
        exp_t e;
        e.res = r;
        e.at  = at;
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (result_valid) begin
            check("valid_single_cycle", int'(prev_vld), 0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: result=%0d at cycle %0d, none expected", result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", int'(result), e.res);
                check("sb_latency_cycle", cyc, e.at);
            end
        end
        prev_vld = result_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int c;
        reset = 1'b1;
        enable = 1'b0;
        successive_approx = 1'b0;
        vin = 0;
        force_low = 1'b0;
        #3;
        check("rst_dac_code", int'(dac_code), 0);
        check("rst_result", int'(result), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // SAR vin=100, enable held across two conversions
        start(1'b1, 100, s);
        push(100, s + 41);
        push(100, s + 83);
        wait_cyc(s + 41); check("sar100_busy_done", int'(busy), 1);
        wait_cyc(s + 42); check("sar100_busy_idle", int'(busy), 0);
        wait_cyc(s + 43); check("sar100_busy_restart", int'(busy), 1);
        check("sar100_restart_code", int'(dac_code), 128);
        wait_cyc(s + 83); enable = 1'b0;
        wait_cyc(s + 85);

        // SAR edge codes with trial sequences
        start(1'b1, 255, s);
        push(255, s + 41);
        for (int i = 0; i < 8; i++) begin
            wait_cyc(s + 1 + 5 * i);
            check("sar255_trial", int'(dac_code), 256 - (1 << (7 - i)));
        end
        wait_cyc(s + 41); enable = 1'b0;
        wait_cyc(s + 43);

        start(1'b1, 0, s);
        push(0, s + 41);
        for (int i = 0; i < 8; i++) begin
            wait_cyc(s + 1 + 5 * i);
            check("sar0_trial", int'(dac_code), 1 << (7 - i));
        end
        wait_cyc(s + 41); enable = 1'b0;
        wait_cyc(s + 43);

        // Ramp vin=5
        start(1'b0, 5, s);
        push(5, s + 36);
        for (int i = 0; i < 7; i++) begin
            wait_cyc(s + 1 + 5 * i);
            check("ramp5_step", int'(dac_code), i);
        end
        wait_cyc(s + 36); check("ramp5_dac_held", int'(dac_code), 6);
        enable = 1'b0;
        wait_cyc(s + 38);

        // Ramp full scale, no wrap
        start(1'b0, 255, s);
        push(255, s + 1281);
        wait_cyc(s + 1281); check("ramp255_no_wrap", int'(dac_code), 255);
        enable = 1'b0;
        wait_cyc(s + 1282); check("ramp255_idle_dac", int'(dac_code), 0);
        wait_cyc(s + 1284);

        // Abort mid SAR conversion
        start(1'b1, 100, s);
        wait_cyc(s + 20); enable = 1'b0;
        wait_cyc(s + 21);
        check("abort_busy", int'(busy), 0);
        check("abort_dac", int'(dac_code), 0);
        check("abort_result_kept", int'(result), 255);
        wait_cyc(s + 50);

        // Mode change mid-conversion: SAR finishes, next is ramp (T=102)
        start(1'b1, 100, s);
        push(100, s + 41);
        push(100, s + 553);
        wait_cyc(s + 10); successive_approx = 1'b0;
        wait_cyc(s + 43); check("mode_next_ramp_code", int'(dac_code), 0);
        wait_cyc(s + 553); enable = 1'b0;
        wait_cyc(s + 556);

        // Ramp with comparator stuck low at code 0 saturates to 0
        force_low = 1'b1;
        start(1'b0, 77, s);
        push(0, s + 6);
        wait_cyc(s + 6); enable = 1'b0;
        wait_cyc(s + 7); force_low = 1'b0;
        wait_cyc(s + 9);

        // Async reset mid-ramp, then fresh conversion
        start(1'b0, 50, s);
        wait_cyc(s + 30);
        check("pre_reset_busy", int'(busy), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_dac", int'(dac_code), 0);
        check("areset_result", int'(result), 0);
        check("areset_busy", int'(busy), 0);
        check("areset_valid", int'(result_valid), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        c = cyc;
        push(50, c + 261);
        wait_cyc(c + 261); enable = 1'b0;
        wait_cyc(c + 264);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_conversion_sequencer.md
Name: adc_conversion_sequencer

Overview:
Sequences one analog-to-digital conversion channel built from an external DAC (R-2R/PWM) and a comparator. The menu controller supplies enable and successive-approximation mode. Two modes are supported: binary-search (SAR) and linear ramp. Each completed code is published, with a one-cycle valid pulse, to the downstream averaging/scaling/display path.

Parameters:
WIDTH, 8, DAC/result bit width.
SETTLE_CYCLES, 100, clk cycles the DAC/comparator settles per trial; must be >= 2 to cover the input synchronizer.

Ports:
clk  input  1  system clock, all logic rising-edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
enable  input  1  level; high = convert continuously, low = abort/idle.
successive_approx  input  1  1 = SAR mode, 0 = ramp mode; latched at conversion start.
comp_in  input  1  asynchronous comparator output; 1 means Vin >= Vdac.
dac_code  output  WIDTH  trial code driven to the DAC.
result  output  WIDTH  last completed conversion code.
result_valid  output  1  one-cycle pulse when result updates.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async): state=IDLE; dac_code, result, settle counter, bit index, mode latch = 0; result_valid=0; sync flops=0.
- comp_in passes through a 2-flop synchronizer. comp_sync denotes the 2nd flop.
- States: IDLE, SETTLE, DECIDE, DONE.
- IDLE: dac_code=0.
  - enable=1 → latch successive_approx into mode, go to SETTLE.
  - Next dac_code: SAR = 1<<(WIDTH-1), bit index = WIDTH-1. Ramp = 0.
- SETTLE: counter runs 0..SETTLE_CYCLES-1, then DECIDE. dac_code is held.
- DECIDE (1 cycle), action on comp_sync:
  - SAR: comp_sync=0 → clear current bit.
    - Bit index > 0: set next lower bit, decrement index, go to SETTLE.
    - Bit index = 0: go to DONE.
  - Ramp: comp_sync=0 → final = dac_code-1, go to DONE.
  - Ramp: comp_sync=1 and dac_code = 2^WIDTH-1 → final = 2^WIDTH-1, go to DONE.
  - Ramp otherwise: dac_code+1, go to SETTLE.
- DONE (1 cycle): result <= final code (SAR: dac_code), result_valid=1, dac_code held. Next state is IDLE unconditionally. If enable is still high, the next conversion starts from IDLE, one cycle later.
- Latency is counted from the IDLE cycle in which enable is sampled high to the cycle result_valid is high:
  - SAR: WIDTH*(SETTLE_CYCLES+1)+1.
  - Ramp: T*(SETTLE_CYCLES+1)+1, where T = number of codes tried = final+2, or 2^WIDTH if final = max.
- Ramp at code 0: comp_sync=1 always for an ideal comparator. If comp_sync=0 at code 0, result = 0 (saturate, no underflow).
- Abort: enable=0 sampled in SETTLE or DECIDE → IDLE next cycle. dac_code=0, result unchanged, no result_valid. In DONE, enable is ignored and the pulse completes.
- successive_approx changes mid-conversion are ignored until the next IDLE→SETTLE start.
- Async reset mid-conversion: outputs go to reset values without waiting for a clk edge. No result_valid is produced.
- result holds between pulses. result_valid is never high two consecutive cycles.

Test Plan:
- Common bench setup: WIDTH=8, SETTLE_CYCLES=4. Comparator model: comp_in = (vin >= dac_code).
- SAR, vin=100, enable held high → result=100, result_valid exactly 41 cycles after start, single pulse; next conversion begins one cycle after IDLE; busy low only in that IDLE cycle.
- SAR edge codes: vin=0 → result=0; vin=255 → result=255. Both at 41-cycle latency. Trial sequence for vin=255 is 128,192,224,…,255.
- Ramp, vin=5 → dac_code steps 0..6, result=5 at 36 cycles. Ramp, vin=255 → result=255 at 1281 cycles, no wrap of dac_code.
- Abort and mode change:
  - Drop enable at cycle 20 of a SAR conversion → state IDLE, dac_code=0 next cycle, busy=0, previous result retained, no pulse.
  - Toggle successive_approx mid-conversion → current conversion finishes in its latched mode; the next one uses the new mode.
- Assert reset asynchronously between clk edges mid-ramp → dac_code, result, busy, result_valid read 0 before the next edge. On release with enable=1, a fresh conversion completes with correct latency.
